// File: rtl/uart_mem_ctrl.sv
// uart_mem_ctrl: byte-command processor between the UART core and the
// 2^ADDR_W x 16 programming-image memory (synchronous read, 1-cycle latency).
//   'R' addr           -> reply word high byte, then low byte
//   'W' addr hi lo     -> write {hi,lo}, then reply ACK
//   'D'                -> reply every word in address order, high byte first
//   anything else      -> reply NAK and pulse cmd_err_o
// Optional build macro: UART_MEM_CHECKSUM_EN appends a modulo-256 sum byte to
// the dump reply. With the macro undefined no checksum logic exists.
module uart_mem_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic              CLK_UART_i,
  input  logic              RST_UART_i,
  input  logic              valid_rx_i,
  input  logic [7:0]        serial_read_i,
  input  logic              busy_tx_i,
  output logic              start_tx_o,
  output logic [7:0]        serial_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  output logic              mem_we_o,
  input  logic [15:0]       mem_rdata_i,
  output logic              busy_o,
  output logic              cmd_err_o
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] BYTE_ACK = 8'h06;
  localparam logic [7:0] BYTE_NAK = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_GET_ADDR    = 4'd1,
    S_GET_HI      = 4'd2,
    S_GET_LO      = 4'd3,
    S_MEM_WR      = 4'd4,
    S_MEM_RD      = 4'd5,
    S_MEM_RD_WAIT = 4'd6,
    S_TX_LOAD     = 4'd7,
    S_TX_START    = 4'd8,
    S_TX_WAIT_HI  = 4'd9,
    S_TX_WAIT_LO  = 4'd10,
    S_DUMP_NEXT   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2,
    OP_DUMP = 2'd3
  } op_t;

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;         // where the byte-send sequence returns to
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       hold_q, hold_d;       // word read from memory awaiting transmission
  logic              lo_pend_q, lo_pend_d; // low byte of hold_q still to be sent
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              start_tx_q, start_tx_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`ifdef UART_MEM_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign start_tx_o     = start_tx_q;
  assign serial_write_o = tx_byte_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign mem_we_o       = we_q;
  assign busy_o         = busy_q;
  assign cmd_err_o      = err_q;

  // Next-state and registered-output computation for the command FSM.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    lo_pend_d  = lo_pend_q;
    tx_byte_d  = tx_byte_q;
    start_tx_d = 1'b0;
    we_d       = 1'b0;
    err_d      = 1'b0;
    tmo_d      = {TMO_W{1'b0}};
`ifdef UART_MEM_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (valid_rx_i) begin
          if (serial_read_i == CMD_RD) begin
            op_d    = OP_RD;
            state_d = S_GET_ADDR;
          end else if (serial_read_i == CMD_WR) begin
            op_d    = OP_WR;
            state_d = S_GET_ADDR;
          end else if (serial_read_i == CMD_DUMP) begin
            op_d    = OP_DUMP;
            addr_d  = {ADDR_W{1'b0}};
`ifdef UART_MEM_CHECKSUM_EN
            csum_d  = 8'h00;
`endif
            state_d = S_MEM_RD;
          end else begin
            // Unknown command: the NAK byte and the error pulse appear together.
            op_d      = OP_NONE;
            tx_byte_d = BYTE_NAK;
            err_d     = 1'b1;
            lo_pend_d = 1'b0;
            ret_d     = S_IDLE;
            state_d   = S_TX_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_GET_ADDR: begin
        if (valid_rx_i) begin
          addr_d  = serial_read_i[ADDR_W-1:0];
          state_d = (op_q == OP_WR) ? S_GET_HI : S_MEM_RD;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_GET_HI: begin
        if (valid_rx_i) begin
          wdata_d[15:8] = serial_read_i;
          state_d       = S_GET_LO;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_GET_LO: begin
        if (valid_rx_i) begin
          wdata_d[7:0] = serial_read_i;
          we_d         = 1'b1;
          state_d      = S_MEM_WR;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_MEM_WR: begin
        // The write strobe is high during this state; the ACK follows it.
        tx_byte_d = BYTE_ACK;
        lo_pend_d = 1'b0;
        ret_d     = S_IDLE;
        state_d   = S_TX_LOAD;
      end

      S_MEM_RD: begin
        state_d = S_MEM_RD_WAIT;
      end

      S_MEM_RD_WAIT: begin
        hold_d    = mem_rdata_i;
        tx_byte_d = mem_rdata_i[15:8];
        lo_pend_d = 1'b1;
        ret_d     = (op_q == OP_DUMP) ? S_DUMP_NEXT : S_IDLE;
`ifdef UART_MEM_CHECKSUM_EN
        if (op_q == OP_DUMP) begin
          csum_d = csum_q + mem_rdata_i[15:8];
        end else begin
          csum_d = csum_q;
        end
`endif
        state_d = S_TX_LOAD;
      end

      S_TX_LOAD: begin
        state_d = S_TX_START;
      end

      S_TX_START: begin
        if (!busy_tx_i) begin
          start_tx_d = 1'b1;
          state_d    = S_TX_WAIT_HI;
        end else begin
          state_d = S_TX_START;
        end
      end

      S_TX_WAIT_HI: begin
        if (busy_tx_i) begin
          state_d = S_TX_WAIT_LO;
        end else begin
          state_d = S_TX_WAIT_HI;
        end
      end

      S_TX_WAIT_LO: begin
        if (busy_tx_i) begin
          state_d = S_TX_WAIT_LO;
        end else if (lo_pend_q) begin
          tx_byte_d = hold_q[7:0];
          lo_pend_d = 1'b0;
`ifdef UART_MEM_CHECKSUM_EN
          if (op_q == OP_DUMP) begin
            csum_d = csum_q + hold_q[7:0];
          end else begin
            csum_d = csum_q;
          end
`endif
          state_d = S_TX_LOAD;
        end else begin
          state_d = ret_q;
        end
      end

      S_DUMP_NEXT: begin
        if (addr_q == {ADDR_W{1'b1}}) begin
`ifdef UART_MEM_CHECKSUM_EN
          tx_byte_d = csum_q;
          lo_pend_d = 1'b0;
          ret_d     = S_IDLE;
          state_d   = S_TX_LOAD;
`else
          state_d = S_IDLE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_MEM_RD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK_UART_i) begin
    if (RST_UART_i) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      op_q       <= OP_NONE;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= 16'h0000;
      hold_q     <= 16'h0000;
      lo_pend_q  <= 1'b0;
      tx_byte_q  <= 8'h00;
      start_tx_q <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      tmo_q      <= {TMO_W{1'b0}};
`ifdef UART_MEM_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      lo_pend_q  <= lo_pend_d;
      tx_byte_q  <= tx_byte_d;
      start_tx_q <= start_tx_d;
      we_q       <= we_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      tmo_q      <= tmo_d;
`ifdef UART_MEM_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule
